skewed_weight_fifo: RTL and testbench

Parametrised per-column weight buffer feeding an N_COLS-wide systolic array.
- Each column owns a DEPTH-deep FIFO.
- A single common pop dequeues every column together.
- Column c's popped value passes through a c-stage skew pipeline, producing the diagonal wavefront the MMU weight-load sequence requires.
- Adds per-column full/empty/occupancy and bubble-aware valid tagging.

---
 rtl/skewed_weight_fifo.sv | 95 +++++++++
 tb/tb_skewed_weight_fifo.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/skewed_weight_fifo.sv
// skewed_weight_fifo: per-column weight FIFOs with a common pop and a c-stage skew pipeline per column.
// Define SKEW_WEIGHT_FIFO_ERR_EN to add sticky overflow/underflow flags.
module skewed_weight_fifo #(
   parameter int N_COLS = 3,
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic [N_COLS-1:0]                      push,
   input  logic [N_COLS*DATA_W-1:0]               data_in,
   input  logic                                   pop,
   input  logic                                   weight_load_start,
   output logic [N_COLS*DATA_W-1:0]               col_out,
   output logic [N_COLS-1:0]                      col_valid,
   output logic [N_COLS-1:0]                      full,
   output logic [N_COLS-1:0]                      empty,
   output logic [N_COLS*$clog2(DEPTH+1)-1:0]      count,
   output logic                                   pop_ok,
   output logic                                   err_ovf,
   output logic                                   err_udf,
   input  logic                                   err_clr
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   logic [N_COLS-1:0] push_acc;
   assign pop_ok = pop && (empty == '0);
   for (genvar c = 0; c < N_COLS; c++) begin : g_col
      logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
      logic [CW-1:0]     count_q, count_d;
      logic [DATA_W-1:0] mem_q [DEPTH];
      logic [DATA_W-1:0] head;
      logic [DATA_W-1:0] sd_q [c+1];
      logic [DATA_W-1:0] sd_d [c+1];
      logic [c:0]        sv_q, sv_d;
      assign full[c]     = count_q == CW'(DEPTH);
      assign empty[c]    = count_q == '0;
      assign push_acc[c] = push[c] && (!full[c] || pop_ok);
      assign head        = mem_q[rd_ptr_q];
      always_comb begin
         wr_ptr_d = wr_ptr_q + AW'(push_acc[c]);
         rd_ptr_d = rd_ptr_q + AW'(pop_ok);
         count_d  = count_q + CW'(push_acc[c]) - CW'(pop_ok);
         sd_d[0]  = pop_ok ? head : '0;
         sv_d[0]  = pop_ok;
         // a new load sequence drops everything already past stage 0
         for (int k = 1; k <= c; k++) begin
            sd_d[k] = weight_load_start ? '0 : sd_q[k-1];
            sv_d[k] = !weight_load_start && sv_q[k-1];
         end
      end
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            sv_q     <= '0;
            for (int k = 0; k <= c; k++) sd_q[k] <= '0;
         end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            sv_q     <= sv_d;
            for (int k = 0; k <= c; k++) sd_q[k] <= sd_d[k];
         end
      end
      always_ff @(posedge clk) begin
         if (push_acc[c]) mem_q[wr_ptr_q] <= data_in[c*DATA_W +: DATA_W];
      end
      assign col_out[c*DATA_W +: DATA_W] = sd_q[c];
      assign col_valid[c]                = sv_q[c];
      assign count[c*CW +: CW]           = count_q;
   end
`ifdef SKEW_WEIGHT_FIFO_ERR_EN
   logic err_ovf_q, err_ovf_d, err_udf_q, err_udf_d;
   always_comb begin
      err_ovf_d = (|(push & full) && !pop_ok) || (err_ovf_q && !err_clr);
      err_udf_d = (pop && !pop_ok) || (err_udf_q && !err_clr);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_ovf_q <= 1'b0;
         err_udf_q <= 1'b0;
      end else begin
         err_ovf_q <= err_ovf_d;
         err_udf_q <= err_udf_d;
      end
   end
   assign err_ovf = err_ovf_q;
   assign err_udf = err_udf_q;
`else
   assign err_ovf = 1'b0 & err_clr;
   assign err_udf = 1'b0;
`endif
endmodule

// File: tb/tb_skewed_weight_fifo.sv
// tb_skewed_weight_fifo: directed and random steps checked against a queue/history model of the skewed FIFO.
module tb_skewed_weight_fifo;
   localparam int N  = 3;
   localparam int W  = 8;
   localparam int D  = 4;
   localparam int CW = $clog2(D+1);
`ifdef SKEW_WEIGHT_FIFO_ERR_EN
   localparam bit ERR = 1'b1;
`else
   localparam bit ERR = 1'b0;
`endif
   logic clk = 1'b0, rst_n = 1'b1;
   logic [N-1:0]    push = '0;
   logic [N*W-1:0]  data_in = '0;
   logic            pop = 1'b0, wls = 1'b0, err_clr = 1'b0;
   logic [N*W-1:0]  col_out;
   logic [N-1:0]    col_valid, full, empty;
   logic [N*CW-1:0] count;
   logic            pop_ok, err_ovf, err_udf;

   skewed_weight_fifo #(.N_COLS(N), .DATA_W(W), .DEPTH(D)) dut (
      .clk(clk), .rst_n(rst_n), .push(push), .data_in(data_in), .pop(pop),
      .weight_load_start(wls), .col_out(col_out), .col_valid(col_valid),
      .full(full), .empty(empty), .count(count), .pop_ok(pop_ok),
      .err_ovf(err_ovf), .err_udf(err_udf), .err_clr(err_clr));

   always #5 clk = ~clk;

   int n_vec = 0, n_err = 0, cyc = 0, rst_cyc = 0;
   logic [W-1:0] q [N][$];
   bit           hpop [4096];
   bit           hwls [4096];
   logic [W-1:0] hd [4096][N];
   bit           ovf_m = 1'b0, udf_m = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // one clock cycle: drive, check combinational pop_ok, update model, check registered outputs
   task automatic step(input logic [N-1:0] p, input logic [N*W-1:0] d, input bit pp, input bit w, input bit clr);
      bit ok, any_ovf, v;
      int t;
      bit acc [N];
      logic [N*W-1:0]  eo;
      logic [N-1:0]    ev, ef, ee;
      logic [N*CW-1:0] ec;
      push = p; data_in = d; pop = pp; wls = w; err_clr = clr;
      ok = pp;
      for (int c = 0; c < N; c++) if (q[c].size() == 0) ok = 1'b0;
      #1 chk("pop_ok", 64'(pop_ok), 64'(ok));
      any_ovf = 1'b0;
      for (int c = 0; c < N; c++) begin
         acc[c] = p[c] && (q[c].size() < D || ok);
         if (p[c] && q[c].size() == D && !ok) any_ovf = 1'b1;
      end
      hpop[cyc] = ok; hwls[cyc] = w;
      for (int c = 0; c < N; c++) begin
         hd[cyc][c] = ok ? q[c][0] : '0;
         if (ok) void'(q[c].pop_front());
         if (acc[c]) q[c].push_back(d[c*W +: W]);
      end
      ovf_m = any_ovf || (ovf_m && !clr);
      udf_m = (pp && !ok) || (udf_m && !clr);
      @(posedge clk); #1;
      for (int c = 0; c < N; c++) begin
         ec[c*CW +: CW] = CW'(q[c].size());
         ef[c] = q[c].size() == D;
         ee[c] = q[c].size() == 0;
         t = cyc - c;
         v = 1'b0;
         if (t >= rst_cyc) begin
            v = hpop[t];
            for (int j = t + 1; j <= cyc; j++) if (hwls[j]) v = 1'b0;
         end
         ev[c] = v;
         eo[c*W +: W] = v ? hd[t][c] : '0;
      end
      chk("count", 64'(count), 64'(ec));
      chk("full", 64'(full), 64'(ef));
      chk("empty", 64'(empty), 64'(ee));
      chk("col_out", 64'(col_out), 64'(eo));
      chk("col_valid", 64'(col_valid), 64'(ev));
      chk("err_ovf", 64'(err_ovf), 64'(ERR && ovf_m));
      chk("err_udf", 64'(err_udf), 64'(ERR && udf_m));
      cyc++;
   endtask

   task automatic idle(input int n);
      repeat (n) step('0, '0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      #1 rst_n = 1'b0;
      #2;
      chk("rst_count", 64'(count), 64'(0));
      chk("rst_empty", 64'(empty), 64'(3'b111));
      chk("rst_full", 64'(full), 64'(0));
      chk("rst_valid", 64'(col_valid), 64'(0));
      chk("rst_out", 64'(col_out), 64'(0));
      #9 rst_n = 1'b1;
      rst_cyc = 0;
      // basic wavefront
      step(3'b111, {8'h31, 8'h21, 8'h11}, 0, 0, 0);
      step(3'b111, {8'h32, 8'h22, 8'h12}, 0, 0, 0);
      step('0, '0, 1, 0, 0);
      step('0, '0, 1, 0, 0);
      idle(5);
      // pop with column 2 empty
      step(3'b011, {8'h00, 8'h41, 8'h40}, 0, 0, 0);
      step('0, '0, 1, 0, 0);
      step('0, '0, 0, 0, 1);
      step(3'b100, {8'h42, 8'h00, 8'h00}, 0, 0, 0);
      step('0, '0, 1, 0, 0);
      idle(3);
      // overflow on column 1, then push-while-full with accepted pop
      for (int i = 0; i < D; i++) step(3'b010, {8'h00, 8'(8'h50 + i), 8'h00}, 0, 0, 0);
      step(3'b010, {8'h00, 8'hAA, 8'h00}, 0, 0, 0);
      for (int i = 0; i < D; i++) step(3'b101, {8'(8'h70 + i), 8'h00, 8'(8'h60 + i)}, 0, 0, 0);
      step(3'b010, {8'h00, 8'hBB, 8'h00}, 1, 0, 0);
      repeat (3) step('0, '0, 1, 0, 0);
      step(3'b101, {8'h7F, 8'h00, 8'h6F}, 0, 0, 1);
      step('0, '0, 1, 0, 0);
      idle(4);
      // weight_load_start flushes an in-flight wavefront
      step(3'b111, {3{8'h01}}, 0, 0, 0);
      step(3'b111, {3{8'h02}}, 0, 0, 0);
      step('0, '0, 1, 0, 0);
      step('0, '0, 1, 1, 0);
      idle(5);
      // wrap-around with continuous push/pop
      step(3'b111, N*W'($urandom), 0, 0, 0);
      repeat (10) step(3'b111, N*W'($urandom), 1, 0, 0);
      idle(3);
      // random traffic
      repeat (60) step(N'($urandom), N*W'($urandom), ($urandom % 4) != 0, ($urandom % 8) == 0, ($urandom % 8) == 0);
      // async reset mid-wavefront
      step(3'b111, {8'hC3, 8'hC2, 8'hC1}, 0, 0, 0);
      step(3'b111, {8'hD3, 8'hD2, 8'hD1}, 1, 0, 0);
      step('0, '0, 1, 0, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_out", 64'(col_out), 64'(0));
      chk("arst_valid", 64'(col_valid), 64'(0));
      chk("arst_empty", 64'(empty), 64'(3'b111));
      chk("arst_count", 64'(count), 64'(0));
      chk("arst_pop_ok", 64'(pop_ok), 64'(0));
      push = '0; pop = 1'b0;
      for (int c = 0; c < N; c++) q[c].delete();
      ovf_m = 1'b0; udf_m = 1'b0;
      #3 rst_n = 1'b1;
      rst_cyc = cyc;
      idle(2);
      step(3'b111, {8'hE3, 8'hE2, 8'hE1}, 0, 0, 0);
      step('0, '0, 1, 0, 0);
      idle(4);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
